rnd_key_scheduler: RTL and testbench
====================================

Name: rnd_key_scheduler

Overview:
- Sequences the shared 8-bit LFSR random generator and arbitrates it between two requesters, the C&C-side and terminal-side cipher key loaders.
- Runs the generator warm-up after reset, then delivers bursts of BURST_LEN random bytes to one requester at a time over a valid/ack handshake.
- Requesters are served round-robin.

Parameters:
- BURST_LEN, 4: bytes per grant (1..15).
- WARMUP_TIMEOUT, 32: max cycles in WARM waiting for gen_rdy before entering ERR.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  2  level requests; bit0 = C&C, bit1 = terminal.
- gnt  out  2  one-hot grant, held for the whole burst.
- rnd_data  out  8  random byte to the granted requester.
- rnd_valid  out  1  rnd_data is valid.
- rnd_last  out  1  final byte of the burst; qualified by rnd_valid.
- rnd_ack  in  1  consumer accepts the byte at a clock edge where rnd_valid=1.
- gen_start  out  1  drives the generator start input.
- gen_ena  out  1  drives the generator ena input; each cycle high = one LFSR step.
- gen_value  in  8  generator register value.
- gen_rdy  in  1  generator warm-up done flag.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky warm-up timeout flag.

Behaviour:
- Reset values while rst=0:
  - Outputs: gnt=00, rnd_data=0x00, rnd_valid=0, rnd_last=0, gen_start=0, gen_ena=0, busy=0, err=0.
  - Internal: rr pointer=0 (req0 favoured), byte counter=0, state=WARM.
  - The generator shares this reset, inverted at top level.
- States: WARM, IDLE, STEP, CAP, DELIVER, ERR.
- WARM:
  - gen_start=gen_ena=1 every cycle.
  - gen_rdy sampled 1 -> IDLE, with gen_ena low from the next cycle.
  - WARMUP_TIMEOUT cycles elapse without gen_rdy -> ERR.
  - gen_rdy is consulted only in WARM; it toggles afterwards and is ignored.
- ERR: err=1, busy=1, gnt=00, gen_ena=0. Requests are ignored. Only reset exits ERR.
- IDLE, request handling:
  - A req sampled at edge N -> gnt set and state=STEP after edge N.
  - With both requests set, grant the bit selected by rr; otherwise grant the single requester.
  - rr updates to the non-granted index when the burst completes.
- STEP: gen_ena=gen_start=1 for exactly one cycle (combinational decode of state) -> CAP.
- CAP:
  - rnd_data<=gen_value, rnd_valid<=1, rnd_last<=(count==BURST_LEN-1) -> DELIVER.
  - First rnd_valid is therefore high after edge N+2.
- DELIVER:
  - rnd_data, rnd_valid and rnd_last stay stable, and gen_ena=0, until rnd_ack=1 at an edge.
  - On ack: rnd_valid<=0 and count++.
  - If the byte was last: count<=0, gnt<=00, rr toggled -> IDLE. Otherwise -> STEP.
  - Minimum byte period is 3 cycles; rnd_valid is low for 2 cycles between bytes.
- rnd_ack while rnd_valid=0: ignored.
- A req drop mid-burst is ignored and the burst completes. A req still high after the last ack is arbitrated again in IDLE.
- gnt never changes while busy, except on the final ack and on reset.
- Reset mid-burst: everything aborts immediately to reset values; WARM repeats.

Optional Feature:
- RND_DUP_FILTER_EN defined:
  - Internal register prev_byte, reset 0x00.
  - In CAP, if gen_value==prev_byte: rnd_valid stays 0, count is unchanged, and state returns to STEP.
  - Otherwise the byte is delivered and prev_byte<=gen_value. prev_byte is shared across requesters.
- RND_DUP_FILTER_EN undefined: every stepped value is delivered, and prev_byte logic is absent.

Test Plan:
- Warm-up:
  - Stimulus: rst low 3 cycles; stub raises gen_rdy after 11 enabled cycles.
  - Response: all outputs 0 during reset; gen_ena high exactly 11 cycles; busy falls; err=0.
- Single burst:
  - Stimulus: BURST_LEN=4; req=01 at edge N; stub gen_value sequence 0x11,0x22,0x33,0x44; rnd_ack tied 1.
  - Response: gnt=01 after N; rnd_valid after N+2; bytes 0x11..0x44 in order; rnd_last only with 0x44; gnt=00 after the last ack.
- Round-robin:
  - Stimulus: req=11 held for 3 bursts.
  - Response: gnt sequence 01, 10, 01; no overlap; one IDLE cycle between grants.
- Backpressure:
  - Stimulus: rnd_ack low 5 cycles on byte 2 (0x22).
  - Response: rnd_data=0x22 and rnd_valid=1 stable; gen_ena=0 throughout; no extra LFSR step.
- Timeout:
  - Stimulus: gen_rdy held 0; req=11.
  - Response: err=1 after 32 WARM cycles; gnt stays 00; gen_ena=0 until reset.
- Duplicate filter:
  - Stimulus: stub values 0x55,0x55,0x66,0x77,0x88.
  - Response with RND_DUP_FILTER_EN: delivers 0x55,0x66,0x77,0x88 using 5 steps.
  - Response without: delivers 0x55,0x55,0x66,0x77.

Source files
------------

// File: rtl/rnd_key_scheduler_if.sv
// Consumer-side bundle of rnd_key_scheduler: level requests, one-hot grant
// and the valid/ack byte channel.
interface rnd_key_scheduler_if;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       rnd_last;
  logic       rnd_ack;

  modport master (
    input  req, rnd_ack,
    output gnt, rnd_data, rnd_valid, rnd_last
  );

  modport slave (
    output req, rnd_ack,
    input  gnt, rnd_data, rnd_valid, rnd_last
  );
endinterface

// File: rtl/rnd_key_scheduler.sv
// Warms up the shared 8-bit LFSR, then hands out BURST_LEN-byte bursts to two
// requesters round-robin. Define RND_DUP_FILTER_EN to skip repeated bytes.
module rnd_key_scheduler #(
  parameter int BURST_LEN      = 4,
  parameter int WARMUP_TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  rnd_key_scheduler_if.master   bus,
  output logic                  gen_start,
  output logic                  gen_ena,
  input  logic [7:0]            gen_value,
  input  logic                  gen_rdy,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_WARM, S_IDLE, S_STEP, S_CAP, S_DELIVER, S_ERR
  } state_e;

  localparam int          WARM_W    = $clog2(WARMUP_TIMEOUT + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_TIMEOUT - 1);
  localparam logic [3:0]  LAST_IDX  = 4'(BURST_LEN - 1);

  state_e            state_q, state_d;
  logic [WARM_W-1:0] warm_cnt;
  logic [3:0]        count;
  logic              rr;
  logic [1:0]        gnt_q;
  logic [7:0]        data_q;
  logic              valid_q;
  logic              last_q;
  logic [1:0]        pick;
  logic              dup;

  assign bus.gnt       = gnt_q;
  assign bus.rnd_data  = data_q;
  assign bus.rnd_valid = valid_q;
  assign bus.rnd_last  = last_q;

  // With both requesters asking, rr chooses; otherwise the lone request is already one-hot.
  assign pick = (bus.req == 2'b11) ? (rr ? 2'b10 : 2'b01) : bus.req;

`ifdef RND_DUP_FILTER_EN
  logic [7:0] prev_byte;

  assign dup = (gen_value == prev_byte);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          prev_byte <= 8'h00;
    else if (state_q == S_CAP && !dup) prev_byte <= gen_value;
  end
`else
  assign dup = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_WARM;
    else      state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WARM: begin
        if (gen_rdy)                    state_d = S_IDLE;
        else if (warm_cnt == WARM_LAST) state_d = S_ERR;
      end
      S_IDLE:    if (|bus.req) state_d = S_STEP;
      S_STEP:    state_d = S_CAP;
      S_CAP:     state_d = dup ? S_STEP : S_DELIVER;
      S_DELIVER: if (bus.rnd_ack) state_d = last_q ? S_IDLE : S_STEP;
      S_ERR:     state_d = S_ERR;
      default:   state_d = S_WARM;
    endcase
  end

  // NOTE: the decode is masked by rst so the generator controls and status
  // flags read 0 while reset is held, even though the state register is WARM.
  always_comb begin
    gen_start = 1'b0;
    gen_ena   = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    if (rst) begin
      gen_ena   = (state_q == S_WARM) || (state_q == S_STEP);
      gen_start = gen_ena;
      busy      = (state_q != S_IDLE);
      err       = (state_q == S_ERR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_cnt <= '0;
      count    <= 4'd0;
      rr       <= 1'b0;
      gnt_q    <= 2'b00;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      case (state_q)
        S_WARM: warm_cnt <= warm_cnt + 1'b1;
        S_IDLE: if (|bus.req) gnt_q <= pick;
        S_CAP: begin
          if (!dup) begin
            data_q  <= gen_value;
            valid_q <= 1'b1;
            last_q  <= (count == LAST_IDX);
          end
        end
        S_DELIVER: begin
          if (bus.rnd_ack) begin
            valid_q <= 1'b0;
            if (last_q) begin
              last_q <= 1'b0;
              count  <= 4'd0;
              gnt_q  <= 2'b00;
              rr     <= gnt_q[0];  // point at the requester that was not served
            end else begin
              count  <= count + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rnd_key_scheduler.sv
// Directed bench for rnd_key_scheduler with a stub LFSR that replays loaded
// byte tables; covers warm-up, bursts, round-robin, backpressure, timeout, filter.
module tb_rnd_key_scheduler;

  localparam int BURST_LEN      = 4;
  localparam int WARMUP_TIMEOUT = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       gen_start, gen_ena, gen_rdy, busy, err;
  logic [7:0] gen_value;

  rnd_key_scheduler_if bus ();

  rnd_key_scheduler #(
    .BURST_LEN      (BURST_LEN),
    .WARMUP_TIMEOUT (WARMUP_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .gen_start (gen_start),
    .gen_ena   (gen_ena),
    .gen_value (gen_value),
    .gen_rdy   (gen_rdy),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         ena_cnt;
  int         val_base = 100000;
  logic [7:0] vals [16];
  bit         rdy_block = 1'b0;
  logic [7:0] got_data [$];
  logic       got_last [$];
  logic [1:0] seq [$];
  int         gaps [$];
  int         zero_run, bad_oh, n_ena, n_warm, bad_cnt;
  logic [1:0] prev_gnt;

  // Stub generator: counts enabled edges, flags ready during the 11th enabled
  // cycle, then toggles ready; each step after a table load presents the next byte.
  always @(posedge clk or negedge rst) begin
    if (!rst)         ena_cnt <= 0;
    else if (gen_ena) ena_cnt <= ena_cnt + 1;
  end

  always_comb begin
    gen_rdy   = !rdy_block && (ena_cnt == 10 || (ena_cnt > 10 && ena_cnt[0]));
    gen_value = 8'h00;
    if (ena_cnt > val_base && ena_cnt - val_base <= 16)
      gen_value = vals[4'(ena_cnt - val_base - 1)];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {bus.gnt, bus.rnd_data, bus.rnd_valid, bus.rnd_last, gen_start, gen_ena, busy, err};
  endfunction

  task automatic load_vals(input logic [127:0] v);
    for (int i = 0; i < 16; i++) vals[i] = v[127-8*i -: 8];
    val_base = ena_cnt;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({tag, "_rst_outs"}, 32'(outs()), 32'h0);
    repeat (3) @(negedge clk);
    check({tag, "_rst_hold"}, 32'(outs()), 32'h0);
    rst = 1'b1;
    #1;
  endtask

  task automatic wait_warm(output int cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (gen_ena) cycles++;
      if (!busy || err) break;
      @(negedge clk);
    end
  endtask

  task automatic collect(input string tag, input int n, input int budget);
    got_data.delete();
    got_last.delete();
    for (int i = 0; i < budget; i++) begin
      if (bus.rnd_valid && bus.rnd_ack) begin
        got_data.push_back(bus.rnd_data);
        got_last.push_back(bus.rnd_last);
      end
      if (got_data.size() >= n) break;
      @(negedge clk);
    end
    check({tag, "_count"}, got_data.size(), n);
  endtask

  task automatic check_bytes(input string tag, input logic [31:0] exp_d, input logic [3:0] exp_l);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_data%0d", tag, k),
            (k < got_data.size()) ? 32'(got_data[k]) : 32'hxxxx_xxxx, 32'(exp_d[31-8*k -: 8]));
      check($sformatf("%s_last%0d", tag, k),
            (k < got_last.size()) ? 32'(got_last[k]) : 32'hxxxx_xxxx, 32'(exp_l[3-k]));
    end
  endtask

  // Wait for a byte, optionally withhold ack for `hold` cycles, then ack it.
  task automatic take_byte(input string tag, input logic [7:0] exp_data,
                           input logic exp_last, input int hold);
    int base;
    int bad;
    for (int i = 0; i < 20 && !bus.rnd_valid; i++) @(negedge clk);
    check({tag, "_valid"}, 32'(bus.rnd_valid), 32'h1);
    check({tag, "_data"},  32'(bus.rnd_data),  32'(exp_data));
    check({tag, "_last"},  32'(bus.rnd_last),  32'(exp_last));
    if (hold > 0) begin
      base = ena_cnt;
      bad  = 0;
      repeat (hold) begin
        @(negedge clk);
        if (!bus.rnd_valid || bus.rnd_data !== exp_data || gen_ena) bad++;
      end
      check({tag, "_stable"},  bad, 0);
      check({tag, "_no_step"}, ena_cnt, base);
    end
    bus.rnd_ack = 1'b1;
    @(negedge clk);
    bus.rnd_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req     = 2'b00;
    bus.rnd_ack = 1'b0;

    // Warm-up
    do_reset("wu");
    wait_warm(n_ena);
    check("wu_ena_cycles", n_ena, 11);
    check("wu_busy", 32'(busy), 32'h0);
    check("wu_err",  32'(err),  32'h0);
    check("wu_gen_ena_low", 32'(gen_ena), 32'h0);

    // Single burst from C&C with ack tied high; request dropped after grant
    load_vals({8'h11, 8'h22, 8'h33, 8'h44, 96'h0});
    bus.rnd_ack = 1'b1;
    bus.req     = 2'b01;
    @(negedge clk);
    check("sb_gnt",   32'(bus.gnt), 32'h1);
    check("sb_step",  32'(gen_ena), 32'h1);
    check("sb_valid_n1", 32'(bus.rnd_valid), 32'h0);
    bus.req = 2'b00;
    @(negedge clk);
    check("sb_valid_cap", 32'(bus.rnd_valid), 32'h0);
    @(negedge clk);
    check("sb_valid_n2", 32'(bus.rnd_valid), 32'h1);
    collect("sb", 4, 40);
    check_bytes("sb", 32'h11223344, 4'b0001);
    @(negedge clk);
    check("sb_gnt_end",  32'(bus.gnt), 32'h0);
    check("sb_busy_end", 32'(busy),    32'h0);

    // Backpressure on byte 2 for the terminal requester
    load_vals({8'h11, 8'h22, 8'h33, 8'h44, 96'h0});
    bus.rnd_ack = 1'b0;
    bus.req     = 2'b10;
    @(negedge clk);
    check("bp_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 2'b00;
    take_byte("bp0", 8'h11, 1'b0, 0);
    take_byte("bp1", 8'h22, 1'b0, 5);
    take_byte("bp2", 8'h33, 1'b0, 0);
    take_byte("bp3", 8'h44, 1'b1, 0);
    check("bp_gnt_end", 32'(bus.gnt), 32'h0);

    // Round-robin with both requests held for three bursts
    load_vals(128'hA1A2A3A4_A5A6A7A8_A9AAABAC_ADAEAFB0);
    bus.rnd_ack = 1'b1;
    bus.req     = 2'b11;
    seq.delete();
    gaps.delete();
    zero_run = 0;
    bad_oh   = 0;
    prev_gnt = 2'b00;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!$onehot0(bus.gnt)) bad_oh++;
      if (bus.gnt != 2'b00 && prev_gnt == 2'b00) begin
        seq.push_back(bus.gnt);
        if (seq.size() > 1) gaps.push_back(zero_run);
        if (seq.size() == 3) bus.req = 2'b00;
      end
      if (bus.gnt == 2'b00) zero_run++;
      else                  zero_run = 0;
      prev_gnt = bus.gnt;
      if (seq.size() == 3 && bus.gnt == 2'b00) break;
    end
    check("rr_grants", seq.size(), 3);
    check("rr_g0", (seq.size() > 0) ? 32'(seq[0]) : 32'hx, 32'h1);
    check("rr_g1", (seq.size() > 1) ? 32'(seq[1]) : 32'hx, 32'h2);
    check("rr_g2", (seq.size() > 2) ? 32'(seq[2]) : 32'hx, 32'h1);
    check("rr_gap0", (gaps.size() > 0) ? gaps[0] : -1, 1);
    check("rr_gap1", (gaps.size() > 1) ? gaps[1] : -1, 1);
    check("rr_onehot", bad_oh, 0);
    check("rr_gnt_end", 32'(bus.gnt), 32'h0);

    // Duplicate-byte handling
    load_vals({8'h55, 8'h55, 8'h66, 8'h77, 8'h88, 88'h0});
    bus.rnd_ack = 1'b1;
    bus.req     = 2'b01;
    @(negedge clk);
    bus.req = 2'b00;
    collect("dup", 4, 60);
    @(negedge clk);
    check("dup_gnt_end", 32'(bus.gnt), 32'h0);
`ifdef RND_DUP_FILTER_EN
    check_bytes("dup", 32'h55667788, 4'b0001);
    check("dup_steps", ena_cnt - val_base, 5);
`else
    check_bytes("dup", 32'h55556677, 4'b0001);
    check("dup_steps", ena_cnt - val_base, 4);
`endif

    // Warm-up timeout with requests pending
    rdy_block   = 1'b1;
    bus.req     = 2'b11;
    bus.rnd_ack = 1'b0;
    do_reset("to");
    n_warm = 0;
    n_ena  = 0;
    for (int i = 0; i < 100; i++) begin
      if (err) break;
      if (gen_ena) n_ena++;
      n_warm++;
      @(negedge clk);
    end
    check("to_warm_cycles", n_warm, WARMUP_TIMEOUT);
    check("to_ena_cycles",  n_ena,  WARMUP_TIMEOUT);
    bad_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.gnt != 2'b00 || gen_ena || !err || !busy) bad_cnt++;
    end
    check("to_err_hold", bad_cnt, 0);

    // Reset clears ERR; then abort a burst with reset mid-delivery
    rdy_block = 1'b0;
    bus.req   = 2'b00;
    do_reset("mid");
    wait_warm(n_ena);
    check("mid_ena_cycles", n_ena, 11);
    load_vals({8'h3C, 8'h4D, 8'h5E, 8'h6F, 96'h0});
    bus.req = 2'b01;
    for (int i = 0; i < 20 && !bus.rnd_valid; i++) @(negedge clk);
    check("mid_valid", 32'(bus.rnd_valid), 32'h1);
    check("mid_data",  32'(bus.rnd_data),  32'h3C);
    rst = 1'b0;
    #1;
    check("mid_abort_outs", 32'(outs()), 32'h0);
    bus.req = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rewarm", 32'({busy, gen_ena, gen_start}), 32'h7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
